dmem_dump_reader: RTL
=====================

# dmem_dump_reader

Hardware read-back engine for the byte-laned data memory of the single-cycle RISC-V core. On a start command it walks a contiguous range of word addresses, reads the four byte lanes through a synchronous read port, assembles each little-endian 32-bit word and emits it, with its address, on a valid/ready stream. It sits beside the data memory as the read-out counterpart of the test preload path, so benches and a debug UART can dump post-run memory state without hierarchical peeks.

## Interface
- ADDR_WIDTH, 8, word-address width of the data memory; depth is 2^ADDR_WIDTH words
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first word address, captured on accepted start
- word_count  input  ADDR_WIDTH+1  number of words to dump, 0..2^ADDR_WIDTH, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the dump completes
- mem_re  output  1  read enable to all four byte lanes
- mem_addr  output  ADDR_WIDTH  word address to all four byte lanes
- mem_rdata_b0..mem_rdata_b3  input  8 each  lane read data, valid the cycle after mem_re
- out_valid  output  1  stream word valid
- out_ready  input  1  stream consumer ready
- out_addr  output  ADDR_WIDTH  word address of out_data
- out_data  output  32  assembled word {b3,b2,b1,b0}
- checksum  output  32  running sum of emitted words (see Configuration)

## Operation
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE: start=1 captures base_addr into addr, word_count into remaining, clears checksum; remaining=0 -> DONE, else -> READ.
- READ: mem_re=1, mem_addr=addr for exactly one cycle -> CAPT.
- CAPT: register out_data={b3,b2,b1,b0}, out_addr=addr -> SEND.
- SEND: out_valid=1; out_data/out_addr held stable until out_valid&&out_ready. On handshake: checksum += out_data (mod 2^32), addr+1 (mod 2^ADDR_WIDTH, wraps), remaining-1; remaining became 0 -> DONE, else -> READ.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start outside IDLE ignored; base_addr/word_count changes after capture ignored.
- Block never writes memory; mem_re is the only memory strobe.

## Timing
- Reset (any state, mid-dump included): state IDLE; busy, done, mem_re, out_valid = 0; mem_addr, out_addr, out_data, checksum = 0; partially sent dump abandoned, no done pulse.
- Start accepted at edge N: busy=1 from N+1; first mem_re at N+1; out_valid at N+3 earliest.
- Per word with out_ready held 1: 3 cycles (READ, CAPT, SEND); n words -> done at cycle N+3n+1.
- word_count=0: no mem_re, no out_valid; done pulse the cycle after start.
- Backpressure: each stalled cycle in SEND adds one cycle; no reissued read.
- word_count=2^ADDR_WIDTH with nonzero base_addr: address wraps to 0 and continues; every address emitted exactly once.
- busy and done never high together.

## Configuration
- DMEM_DUMP_CHECKSUM_EN defined: checksum accumulator implemented as above, cleared on accepted start, value valid and stable in DONE and IDLE.
- Not defined: no accumulator; checksum tied to 32'h0; all other behaviour identical.

## Test plan
- Lanes mem[0]=12,34,78,56 and mem[1]=F0,DE,BC,9A; base 0, count 2, out_ready=1 -> (addr 0, 32'h56783412) then (addr 1, 32'h9ABCDEF0), done 7 cycles after start; checksum 32'hF1351302 with macro, 0 without.
- Same dump, out_ready low 4 cycles in first SEND -> out_data/out_addr stable throughout, same two words, done delayed exactly 4 cycles.
- word_count=0 -> no mem_re, no out_valid, done one cycle after start, busy stays 0.
- ADDR_WIDTH=8, base 255, count 2 -> words from addr 255 then addr 0.
- Assert rst during second SEND of a 4-word dump -> all outputs 0 next cycle, no done; fresh start re-dumps from base correctly.
- start pulsed while busy with different base_addr -> ignored, original dump completes unchanged.

Source files
------------

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks a word-address range of the byte-laned data memory,
// assembles little-endian 32-bit words and streams them out with their address.
// Optional feature macro: DMEM_DUMP_CHECKSUM_EN adds a running sum of emitted
// words on o_checksum; without it o_checksum is tied to zero.
module dmem_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [7:0]            i_mem_rdata_b0,
  input  logic [7:0]            i_mem_rdata_b1,
  input  logic [7:0]            i_mem_rdata_b2,
  input  logic [7:0]            i_mem_rdata_b3,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ADDR_WIDTH-1:0] o_out_addr,
  output logic [31:0]           o_out_data,
  output logic [31:0]           o_checksum
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_addr_next;
  logic [CW-1:0]   r_remaining;
  logic            r_busy;
  logic            r_done;
  logic            r_mem_re;
  logic [AW-1:0]   r_mem_addr;
  logic            r_out_valid;
  logic [AW-1:0]   r_out_addr;
  logic [31:0]     r_out_data;
  logic            w_accept;
  logic            w_hs;
  logic            w_last;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_hs     = (r_state == S_SEND) && i_out_ready;
  assign w_last   = (r_remaining == CW'(1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and next word address
  always_comb begin
    w_next      = r_state;
    w_addr_next = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr_next = i_base_addr;
          w_next      = (i_word_count == CW'(0)) ? S_DONE : S_READ;
        end
      end
      S_READ: w_next = S_CAPT;
      S_CAPT: w_next = S_SEND;
      S_SEND: begin
        if (i_out_ready) begin
          w_addr_next = r_addr + AW'(1);
          w_next      = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered status and memory strobes, decoded from the upcoming state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy      <= (w_next == S_READ) || (w_next == S_CAPT) || (w_next == S_SEND);
      r_done      <= (w_next == S_DONE);
      r_mem_re    <= (w_next == S_READ);
      r_out_valid <= (w_next == S_SEND);
      if (w_next == S_READ) begin
        r_mem_addr <= w_addr_next;
      end
    end
  end

  // Address walker and remaining-word counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_addr <= w_addr_next;
      if (w_accept) begin
        r_remaining <= i_word_count;
      end else if (w_hs) begin
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

  // Capture lane data into the output word, held stable through SEND
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data <= '0;
      r_out_addr <= '0;
    end else if (r_state == S_CAPT) begin
      r_out_data <= {i_mem_rdata_b3, i_mem_rdata_b2, i_mem_rdata_b1, i_mem_rdata_b0};
      r_out_addr <= r_addr;
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running modulo-2^32 sum of words accepted by the consumer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 32'h0;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mem_re    = r_mem_re;
  assign o_mem_addr  = r_mem_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;

endmodule
